// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment display path: the dark pattern,
// the hex-to-segment table and a width helper that never returns zero.
package sseg_pkg;

  // All segments and the decimal point off (active-low outputs).
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low patterns for nibbles 0..F with the decimal point off.
  // Bit 7 is dp, bits 6:0 are segments g..a.
  localparam logic [7:0] HEX_SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h98, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E
  };

  // Bits needed to index n items, with a floor of 1 so a one-digit
  // display still gets a real index port.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sseg_hex_encoder.sv
// Combinational nibble-to-segment encoder: looks the nibble up in the
// shared table and overlays the decimal point (dp=1 lights it).
module sseg_hex_encoder
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  // Table lookup for g..a; bit 7 is driven low when the dp is requested.
  always_comb begin
    seg      = HEX_SEG_TABLE[nibble];
    seg[7]   = ~dp;
  end

endmodule

// File: rtl/sseg_scan_display.sv
// Multiplexed common-anode seven-segment driver. A load strobe captures the
// packed hex word plus dp/blank masks into shadow registers; a prescaler
// then scans the digits one slot at a time with a short all-dark gap at the
// start of every slot to prevent ghosting. All display outputs are registered.
//
// Interface timing: load is a one-cycle strobe with no ready/backpressure;
// the block accepts it on any rising edge where reset_n=1 and the new value
// is visible on sseg from the following edge. enable gates the scan only.
module sseg_scan_display
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter bit LZ_BLANK     = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 enable,
  input  logic                                 load,
  input  logic [4*NUM_DIGITS-1:0]              data_in,
  input  logic [NUM_DIGITS-1:0]                dp_in,
  input  logic [NUM_DIGITS-1:0]                blank_in,
  output logic [7:0]                           sseg,
  output logic [NUM_DIGITS-1:0]                an,
  output logic [clog2_min1(NUM_DIGITS)-1:0]    digit_idx
);

  localparam int IDX_W = clog2_min1(NUM_DIGITS);
  localparam int PS_W  = clog2_min1(REFRESH_DIV);

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(REFRESH_DIV - 1);
  localparam logic [PS_W-1:0]  GAP_END  = PS_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic [PS_W-1:0]         prescaler;

  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   digit_dark;
  logic [NUM_DIGITS-1:0]   an_lit;
  logic [7:0]              enc_seg;
  logic                    show_digit;

  // Shadow registers: captured only on the load strobe, otherwise held.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
    end else if (load) begin
      shadow_data  <= data_in;
      shadow_dp    <= dp_in;
      shadow_blank <= blank_in;
    end
  end

  // Slot prescaler and digit index; both freeze while enable is low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prescaler <= '0;
      digit_idx <= '0;
    end else if (enable) begin
      if (prescaler == PS_LAST) begin
        prescaler <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
      end else begin
        prescaler <= prescaler + PS_W'(1);
      end
    end
  end

  // Split the packed shadow word into per-digit nibbles.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib[i] = shadow_data[4*i +: 4];
    end
  end

  // Per-digit dark mask: forced blank, or a leading zero when suppression
  // is on (walks from the top digit down; digit 0 always shows).
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    digit_dark = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero    = upper_zero && (nib[i] == 4'h0);
      digit_dark[i] = shadow_blank[i] || (LZ_BLANK && (i != 0) && upper_zero);
    end
  end

  // One-hot-low anode pattern for the current slot.
  always_comb begin
    an_lit            = '1;
    an_lit[digit_idx] = 1'b0;
  end

  sseg_hex_encoder u_enc (
    .nibble (nib[digit_idx]),
    .dp     (shadow_dp[digit_idx]),
    .seg    (enc_seg)
  );

  // A digit is driven only when scanning, past the anti-ghost gap and not dark.
  always_comb begin
    show_digit = enable && (prescaler >= GAP_END) && !digit_dark[digit_idx];
  end

  // Registered pin drivers, one cycle behind the index/prescaler/shadow state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      an   <= '1;
      sseg <= SEG_OFF;
    end else if (show_digit) begin
      an   <= an_lit;
      sseg <= enc_seg;
    end else begin
      an   <= '1;
      sseg <= SEG_OFF;
    end
  end

endmodule
